ram_based_shift_reg: RTL and testbench



---
 rtl/ram_based_shift_reg.sv | 108 ++++++++++
 tb/tb_ram_based_shift_reg.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ram_based_shift_reg.sv
// ram_based_shift_reg: RAM-backed fixed delay line, Q = Din delayed by exactly TAP clocks.
// Define RAM_SHREG_FILL_MASK_EN to force Q to 0 until TAP samples have been written after reset.
module ram_based_shift_reg #(
  parameter int DSIZE  = 25,
  parameter int WDEPTH = 256,
  parameter int TAP    = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [DSIZE-1:0] Din,
  output logic [DSIZE-1:0] Q
);

  localparam int ASIZE = $clog2(WDEPTH);
  // The read register and the output register each add one clock, so the read
  // trails the write by TAP-1 words to give a total latency of TAP.
  localparam logic [ASIZE-1:0] RD_OFFSET = ASIZE'(TAP - 1);

  if ((TAP < 3) || (TAP > WDEPTH)) begin : g_bad_tap
    $error("ram_based_shift_reg: TAP must lie in 3..WDEPTH");
  end
  if ((WDEPTH & (WDEPTH - 1)) != 0) begin : g_bad_depth
    $error("ram_based_shift_reg: WDEPTH must be a power of two");
  end

  logic [1:0]       rst_pipe_q, rst_pipe_d;
  logic             rst_int;
  logic [ASIZE-1:0] wptr_q, wptr_d;
  logic [ASIZE-1:0] rd_addr;
  logic [DSIZE-1:0] rdata_q;
  logic [DSIZE-1:0] q_q, q_d;
  logic [DSIZE-1:0] mem [WDEPTH];

  always_comb begin
    rst_pipe_d = {rst_pipe_q[0], 1'b0};
  end

  // Assert asynchronously, release two clocks later in step with Clock.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rst_pipe_q <= 2'b11;
    end else begin
      rst_pipe_q <= rst_pipe_d;
    end
  end

  assign rst_int = rst_pipe_q[1];

  always_comb begin
    wptr_d  = wptr_q + ASIZE'(1);
    rd_addr = wptr_q - RD_OFFSET;
  end

  // Contents are never cleared; stale words are either masked or don't-care.
  always_ff @(posedge Clock) begin
    mem[wptr_q] <= Din;
  end

  always_ff @(posedge Clock or posedge rst_int) begin
    if (rst_int) begin
      wptr_q  <= '0;
      rdata_q <= '0;
      q_q     <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rdata_q <= mem[rd_addr];
      q_q     <= q_d;
    end
  end

`ifdef RAM_SHREG_FILL_MASK_EN
  localparam logic [ASIZE:0] TAP_CNT = (ASIZE + 1)'(TAP);

  logic [ASIZE:0] fill_cnt_q, fill_cnt_d;
  logic           filled_q, filled_d;

  always_comb begin
    if (fill_cnt_q == TAP_CNT) begin
      fill_cnt_d = fill_cnt_q;
    end else begin
      fill_cnt_d = fill_cnt_q + (ASIZE + 1)'(1);
    end
    filled_d = (fill_cnt_d == TAP_CNT);
    if (filled_q) begin
      q_d = rdata_q;
    end else begin
      q_d = '0;
    end
  end

  always_ff @(posedge Clock or posedge rst_int) begin
    if (rst_int) begin
      fill_cnt_q <= '0;
      filled_q   <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      filled_q   <= filled_d;
    end
  end
`else
  always_comb begin
    q_d = rdata_q;
  end
`endif

  assign Q = q_q;

endmodule

// File: tb/tb_ram_based_shift_reg.sv
// Scoreboard bench for ram_based_shift_reg: three taps (16, 256, 3) share one random/ramp stream.
// Reference model: history of written samples; Q after the n-th write equals the (n-TAP)-th write.
module tb_ram_based_shift_reg;

  localparam int DW         = 25;
  localparam int DEPTH      = 256;
  localparam int SYNC_EDGES = 2;   // edges after release still held by the reset synchroniser
`ifdef RAM_SHREG_FILL_MASK_EN
  localparam bit MASKED = 1'b1;
`else
  localparam bit MASKED = 1'b0;
`endif

  typedef struct packed {
    logic          chk;
    logic [DW-1:0] val;
  } exp_t;

  logic          Clock;
  logic          Reset;
  logic [DW-1:0] Din;
  logic [DW-1:0] q_out [3];
  int            taps  [3] = '{16, 256, 3};
  string         names [3] = '{"tap16", "tap256", "tap3"};

  exp_t          sb [3][$];
  logic [DW-1:0] hist [$];
  int            nwr;
  int            since_rel;
  int            n_checks = 0;
  int            n_fail   = 0;

  ram_based_shift_reg #(.DSIZE(DW), .WDEPTH(DEPTH), .TAP(16)) u_tap16 (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Q(q_out[0]));
  ram_based_shift_reg #(.DSIZE(DW), .WDEPTH(DEPTH), .TAP(256)) u_tap256 (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Q(q_out[1]));
  ram_based_shift_reg #(.DSIZE(DW), .WDEPTH(DEPTH), .TAP(3)) u_tap3 (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Q(q_out[2]));

  initial begin
    Clock = 1'b1;
    forever #5 Clock = ~Clock;
  end

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: Q got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int tap);
    exp_t e;
    if (nwr > tap) begin
      e.chk = 1'b1;
      e.val = hist[nwr - tap - 1];
    end else begin
      e.chk = MASKED;
      e.val = '0;
    end
    return e;
  endfunction

  task automatic push_zero();
    for (int i = 0; i < 3; i++) sb[i].push_back('{1'b1, '0});
  endtask

  task automatic clear_model();
    since_rel = 0;
    nwr       = 0;
    hist.delete();
  endtask

  // One clock of stimulus: inputs change on the falling edge, expectation is queued for the next rising edge.
  task automatic step(input bit rst_v, input bit ramp);
    @(negedge Clock);
    Reset = rst_v;
    if (rst_v) begin
      Din = '0;
      clear_model();
      push_zero();
    end else begin
      since_rel++;
      if (since_rel <= SYNC_EDGES) begin
        Din = '0;
        push_zero();
      end else begin
        Din = ramp ? DW'(nwr) : DW'($urandom);
        hist.push_back(Din);
        nwr++;
        for (int i = 0; i < 3; i++) sb[i].push_back(model(taps[i]));
      end
    end
  endtask

  // Reset pulse asserted between clock edges; Q must clear before any edge arrives.
  task automatic async_reset_pulse(input int cycles);
    @(negedge Clock);
    Din = DW'($urandom);
    push_zero();
    #2 Reset = 1'b1;
    clear_model();
    #1;
    for (int i = 0; i < 3; i++) cmp({names[i], "_async_rst"}, q_out[i], '0);
    for (int c = 1; c < cycles; c++) step(1'b1, 1'b0);
  endtask

  // Monitor: every rising edge the DUTs present a sample; compare it with the queued expectation.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (sb[i].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s_missing: no expectation queued at %0t", names[i], $time);
        end else begin
          exp_t e;
          e = sb[i].pop_front();
          if (e.chk) cmp(names[i], q_out[i], e.val);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    Din   = '0;
    clear_model();
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
    for (int c = 0; c < 300; c++) step(1'b0, 1'b1);
    for (int c = 0; c < 1200; c++) step(1'b0, 1'b0);
    async_reset_pulse(10);
    for (int c = 0; c < 300; c++) step(1'b0, 1'b1);
    for (int c = 0; c < 300; c++) step(1'b0, 1'b0);
    @(posedge Clock);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
